// File: rtl/video_timing_pkg.sv
// Shared timing presets, pattern-select encodings and colour constants for the
// video pattern generator.
package video_timing_pkg;

  localparam int CNT_W    = 16;
  localparam int BOX_SIZE = 64;

  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;

  localparam int H_ACTIVE_1080P = 1920;
  localparam int H_FP_1080P     = 88;
  localparam int H_SYNC_1080P   = 44;
  localparam int H_BP_1080P     = 148;
  localparam int V_ACTIVE_1080P = 1080;
  localparam int V_FP_1080P     = 4;
  localparam int V_SYNC_1080P   = 5;
  localparam int V_BP_1080P     = 36;

  typedef enum logic [2:0] {
    PAT_BARS  = 3'd0,
    PAT_GREY  = 3'd1,
    PAT_CHECK = 3'd2,
    PAT_BOX   = 3'd3,
    PAT_SOLID = 3'd4
  } pattern_e;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  // Colour-bar order, left to right.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vtg_counter.sv
// Horizontal/vertical raster counters with active-video and sync decode and
// start/end-of-frame strobes; runs whole frames while enabled.
//   state   | meaning
//   ST_IDLE | counters parked at 0, no video or sync activity
//   ST_RUN  | raster scanning; returns to idle only at end of a frame
module vtg_counter
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_720P,
  parameter int   H_FP     = H_FP_720P,
  parameter int   H_SYNC   = H_SYNC_720P,
  parameter int   H_BP     = H_BP_720P,
  parameter int   V_ACTIVE = V_ACTIVE_720P,
  parameter int   V_FP     = V_FP_720P,
  parameter int   V_SYNC   = V_SYNC_720P,
  parameter int   V_BP     = V_BP_720P,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] h_o,
  output logic [CNT_W-1:0] v_o,
  output logic             vde_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             sof_o,
  output logic             eof_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS_C   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SS_C   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             run;
  logic             eol;
  logic             eof;

  assign run = (state_q == ST_RUN);
  assign eol = run && (h_q == H_LAST_C);
  assign eof = eol && (v_q == V_LAST_C);

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (en_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (eol) begin
          h_d = '0;
          v_d = eof ? '0 : v_q + ONE_C;
        end else begin
          h_d = h_q + ONE_C;
        end
        // Dropping enable never truncates a frame.
        if (eof && !en_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign h_o     = h_q;
  assign v_o     = v_q;
  assign vde_o   = run && (h_q < H_ACT_C) && (v_q < V_ACT_C);
  assign hsync_o = (run && (h_q >= H_SS_C) && (h_q < H_SE_C)) ? HS_POL : ~HS_POL;
  assign vsync_o = (run && (v_q >= V_SS_C) && (v_q < V_SE_C)) ? VS_POL : ~VS_POL;
  assign sof_o   = run && (h_q == '0) && (v_q == '0);
  assign eof_o   = eof;

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: raster timing from vtg_counter, per-frame pattern
// latch, moving box position, and one register stage on every output.
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_720P,
  parameter int   H_FP     = H_FP_720P,
  parameter int   H_SYNC   = H_SYNC_720P,
  parameter int   H_BP     = H_BP_720P,
  parameter int   V_ACTIVE = V_ACTIVE_720P,
  parameter int   V_FP     = V_FP_720P,
  parameter int   V_SYNC   = V_SYNC_720P,
  parameter int   V_BP     = V_BP_720P,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   BOX_STEP = 4
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic [23:0] m_pData,
  output logic        m_pVDE,
  output logic        m_pHSync,
  output logic        m_pVSync,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] BAR_W_C  = CNT_W'(H_ACTIVE / 8);
  localparam logic [CNT_W-1:0] BOX_C    = CNT_W'(BOX_SIZE);
  localparam logic [CNT_W-1:0] STEP_C   = CNT_W'(BOX_STEP);
  localparam logic [CNT_W-1:0] BOX_Y0_C = CNT_W'(V_ACTIVE / 2 - BOX_SIZE / 2);
  localparam logic [CNT_W-1:0] BOX_Y1_C = CNT_W'(V_ACTIVE / 2 + BOX_SIZE / 2);

  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic             vde;
  logic             hsync;
  logic             vsync;
  logic             sof;
  logic             eof;

  vtg_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HS_POL   (HS_POL),
    .VS_POL   (VS_POL)
  ) u_vtg (
    .pclk    (pclk),
    .rst     (rst),
    .en_i    (en),
    .h_o     (h),
    .v_o     (v),
    .vde_o   (vde),
    .hsync_o (hsync),
    .vsync_o (vsync),
    .sof_o   (sof),
    .eof_o   (eof)
  );

  logic [2:0]       pat_q, pat_d;
  logic [23:0]      solid_q, solid_d;
  logic [CNT_W-1:0] box_x_q, box_x_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [23:0]      data_q, data_d;
  logic             vde_q, hs_q, vs_q, fs_q;
  logic [2:0]       bar_idx;
  logic             in_box;
  logic [23:0]      pix;

  // Inputs go live on the first pixel of a frame so that pixel already uses them.
  always_comb begin
    pat_d   = sof ? pattern_sel : pat_q;
    solid_d = sof ? solid_rgb : solid_q;
  end

  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (h >= CNT_W'(k) * BAR_W_C) bar_idx = 3'(k);
    end
  end

  assign in_box = (h >= box_x_q) && (h < box_x_q + BOX_C) &&
                  (v >= BOX_Y0_C) && (v < BOX_Y1_C);

  always_comb begin
    pix = RGB_BLACK;
    case (pat_d)
      PAT_BARS:  pix = bar_colour(bar_idx);
      PAT_GREY:  pix = {3{h[7:0]}};
      PAT_CHECK: pix = (h[5] ^ v[5]) ? RGB_WHITE : RGB_BLACK;
      PAT_BOX:   pix = in_box ? RGB_WHITE : RGB_BLACK;
      PAT_SOLID: pix = solid_d;
      default:   pix = RGB_BLACK;
    endcase
  end

  always_comb begin
    box_x_d     = box_x_q;
    frame_cnt_d = frame_cnt_q;
    if (eof) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      // Restart from the left once the next step would push the box past the edge.
      if (box_x_q + STEP_C + BOX_C > H_ACT_C) box_x_d = '0;
      else                                   box_x_d = box_x_q + STEP_C;
    end
    data_d = vde ? pix : RGB_BLACK;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      pat_q       <= '0;
      solid_q     <= '0;
      box_x_q     <= '0;
      frame_cnt_q <= '0;
      data_q      <= '0;
      vde_q       <= 1'b0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      fs_q        <= 1'b0;
    end else begin
      pat_q       <= pat_d;
      solid_q     <= solid_d;
      box_x_q     <= box_x_d;
      frame_cnt_q <= frame_cnt_d;
      data_q      <= data_d;
      vde_q       <= vde;
      hs_q        <= hsync;
      vs_q        <= vsync;
      fs_q        <= sof;
    end
  end

  assign m_pData     = data_q;
  assign m_pVDE      = vde_q;
  assign m_pHSync    = hs_q;
  assign m_pVSync    = vs_q;
  assign frame_start = fs_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: three small-raster instances exercised in parallel.
module tb_video_pattern_gen;

  typedef struct {
    int          f;
    int          h;
    int          v;
    logic [23:0] d;
    logic        vde;
  } vec_t;

  localparam int AH = 14, AV = 7, AF = AH * AV;
  localparam int BH = 1650, BV = 5, BF = BH * BV;
  localparam int CH = 86, CV = 71, CF = CH * CV;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int failures = 0;

  logic        rst_a, en_a, rst_b, en_b, rst_c, en_c;
  logic [2:0]  sel_a, sel_b, sel_c;
  logic [23:0] solid_a, solid_b, solid_c;
  logic [23:0] data_a, data_b, data_c;
  logic        vde_a, vde_b, vde_c, hs_a, hs_b, hs_c, vs_a, vs_b, vs_c;
  logic        fs_a, fs_b, fs_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;

  video_pattern_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1),
    .BOX_STEP(4)) dut_a (
    .pclk(pclk), .rst(rst_a), .en(en_a), .pattern_sel(sel_a), .solid_rgb(solid_a),
    .m_pData(data_a), .m_pVDE(vde_a), .m_pHSync(hs_a), .m_pVSync(vs_a),
    .frame_start(fs_a), .frame_cnt(cnt_a));

  video_pattern_gen #(.H_ACTIVE(1280), .H_FP(110), .H_SYNC(40), .H_BP(220),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1),
    .BOX_STEP(4)) dut_b (
    .pclk(pclk), .rst(rst_b), .en(en_b), .pattern_sel(sel_b), .solid_rgb(solid_b),
    .m_pData(data_b), .m_pVDE(vde_b), .m_pHSync(hs_b), .m_pVSync(vs_b),
    .frame_start(fs_b), .frame_cnt(cnt_b));

  video_pattern_gen #(.H_ACTIVE(80), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(68), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1),
    .BOX_STEP(4)) dut_c (
    .pclk(pclk), .rst(rst_c), .en(en_c), .pattern_sel(sel_c), .solid_rgb(solid_c),
    .m_pData(data_c), .m_pVDE(vde_c), .m_pHSync(hs_c), .m_pVSync(vs_c),
    .frame_start(fs_c), .frame_cnt(cnt_c));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(int f, int h, int v, logic [23:0] d, logic vde);
    vec_t r;
    r.f = f; r.h = h; r.v = v; r.d = d; r.vde = vde;
    return r;
  endfunction

  // Expected {data, vde, hsync, vsync, frame_start} for the 8/2/2/2 x 4/1/1/1 raster.
  function automatic logic [27:0] a_exp(int h, int v, int pat, logic [23:0] solid);
    logic vde, hs, vs, fs;
    logic [23:0] d;
    vde = (h < 8) && (v < 4);
    hs  = (h >= 10) && (h < 12);
    vs  = (v == 5);
    fs  = (h == 0) && (v == 0);
    d   = 24'h0;
    if (vde) begin
      case (pat)
        0: case (h)
             0: d = 24'hFFFFFF; 1: d = 24'hFFFF00; 2: d = 24'h00FFFF; 3: d = 24'h00FF00;
             4: d = 24'hFF00FF; 5: d = 24'hFF0000; 6: d = 24'h0000FF; default: d = 24'h000000;
           endcase
        2: d = ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
        4: d = solid;
        default: d = 24'h0;
      endcase
    end
    return {d, vde, hs, vs, fs};
  endfunction

  vec_t b_q[$];
  vec_t c_q[$];
  int   pat_a [4];
  int   pat_b [3];

  initial begin
    pat_a[0] = 4; pat_a[1] = 0; pat_a[2] = 2; pat_a[3] = 4;
    pat_b[0] = 0; pat_b[1] = 1; pat_b[2] = 2;

    b_q.push_back(mkv(0, 0, 0, 24'hFFFFFF, 1'b1));
    b_q.push_back(mkv(0, 159, 0, 24'hFFFFFF, 1'b1));
    b_q.push_back(mkv(0, 160, 0, 24'hFFFF00, 1'b1));
    b_q.push_back(mkv(0, 320, 0, 24'h00FFFF, 1'b1));
    b_q.push_back(mkv(0, 1279, 0, 24'h000000, 1'b1));
    b_q.push_back(mkv(0, 1280, 0, 24'h000000, 1'b0));
    b_q.push_back(mkv(0, 640, 1, 24'hFF00FF, 1'b1));
    b_q.push_back(mkv(0, 960, 1, 24'h0000FF, 1'b1));
    b_q.push_back(mkv(1, 0, 0, 24'h000000, 1'b1));
    b_q.push_back(mkv(1, 255, 0, 24'hFFFFFF, 1'b1));
    b_q.push_back(mkv(1, 256, 0, 24'h000000, 1'b1));
    b_q.push_back(mkv(1, 18, 1, 24'h121212, 1'b1));
    b_q.push_back(mkv(1, 300, 1, 24'h2C2C2C, 1'b1));
    b_q.push_back(mkv(2, 0, 0, 24'h000000, 1'b1));
    b_q.push_back(mkv(2, 31, 0, 24'h000000, 1'b1));
    b_q.push_back(mkv(2, 32, 0, 24'hFFFFFF, 1'b1));
    b_q.push_back(mkv(2, 100, 0, 24'hFFFFFF, 1'b1));
    b_q.push_back(mkv(2, 64, 1, 24'h000000, 1'b1));
    b_q.push_back(mkv(2, 1280, 1, 24'h000000, 1'b0));
    b_q.push_back(mkv(2, 0, 2, 24'h000000, 1'b0));

    c_q.push_back(mkv(0, 0, 1, 24'h000000, 1'b1));
    c_q.push_back(mkv(0, 0, 2, 24'hFFFFFF, 1'b1));
    c_q.push_back(mkv(0, 63, 2, 24'hFFFFFF, 1'b1));
    c_q.push_back(mkv(0, 64, 2, 24'h000000, 1'b1));
    c_q.push_back(mkv(0, 0, 65, 24'hFFFFFF, 1'b1));
    c_q.push_back(mkv(0, 0, 66, 24'h000000, 1'b1));
    c_q.push_back(mkv(1, 3, 10, 24'h000000, 1'b1));
    c_q.push_back(mkv(1, 4, 10, 24'hFFFFFF, 1'b1));
    c_q.push_back(mkv(1, 67, 10, 24'hFFFFFF, 1'b1));
    c_q.push_back(mkv(1, 68, 10, 24'h000000, 1'b1));
    c_q.push_back(mkv(2, 7, 10, 24'h000000, 1'b1));
    c_q.push_back(mkv(2, 8, 10, 24'hFFFFFF, 1'b1));
    c_q.push_back(mkv(2, 71, 10, 24'hFFFFFF, 1'b1));
    c_q.push_back(mkv(2, 72, 10, 24'h000000, 1'b1));
    c_q.push_back(mkv(3, 11, 10, 24'h000000, 1'b1));
    c_q.push_back(mkv(3, 12, 10, 24'hFFFFFF, 1'b1));
    c_q.push_back(mkv(3, 75, 10, 24'hFFFFFF, 1'b1));
    c_q.push_back(mkv(3, 76, 10, 24'h000000, 1'b1));
    c_q.push_back(mkv(4, 15, 10, 24'h000000, 1'b1));
    c_q.push_back(mkv(4, 16, 10, 24'hFFFFFF, 1'b1));
    c_q.push_back(mkv(4, 79, 10, 24'hFFFFFF, 1'b1));
    c_q.push_back(mkv(5, 0, 10, 24'hFFFFFF, 1'b1));
    c_q.push_back(mkv(5, 16, 10, 24'hFFFFFF, 1'b1));
    c_q.push_back(mkv(5, 63, 10, 24'hFFFFFF, 1'b1));
    c_q.push_back(mkv(5, 64, 10, 24'h000000, 1'b1));

    rst_a = 1'b1; en_a = 1'b0; sel_a = 3'd4; solid_a = 24'h123456;
    rst_b = 1'b1; en_b = 1'b0; sel_b = 3'd0; solid_b = 24'h0;
    rst_c = 1'b1; en_c = 1'b0; sel_c = 3'd3; solid_c = 24'h0;

    fork
      begin : thread_a
        int vde_n, hs_n, vs_n;
        vde_n = 0; hs_n = 0; vs_n = 0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("a_reset_out", {data_a, vde_a, hs_a, vs_a, fs_a}, 28'h0);
        chk("a_reset_cnt", cnt_a, 16'd0);
        rst_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge pclk);
          chk("a_idle_en_low", {data_a, vde_a, hs_a, vs_a, fs_a}, 28'h0);
        end
        en_a = 1'b1;
        @(negedge pclk);
        chk("a_en_lat0", {data_a, vde_a, hs_a, vs_a, fs_a}, 28'h0);
        @(negedge pclk);
        chk("a_first_px", {data_a, vde_a, hs_a, vs_a, fs_a}, a_exp(0, 0, 4, 24'h123456));
        for (int n = 1; n <= 31; n++) begin
          @(negedge pclk);
          chk($sformatf("a_abort_px%0d", n), {data_a, vde_a, hs_a, vs_a, fs_a},
              a_exp(n % AH, n / AH, 4, 24'h123456));
        end
        rst_a = 1'b1;
        @(negedge pclk);
        chk("a_rst_mid_out", {data_a, vde_a, hs_a, vs_a, fs_a}, 28'h0);
        chk("a_rst_mid_cnt", cnt_a, 16'd0);
        for (int i = 0; i < 3; i++) begin
          @(negedge pclk);
          chk("a_rst_hold", {data_a, vde_a, hs_a, vs_a, fs_a}, 28'h0);
        end
        rst_a = 1'b0;
        @(negedge pclk);
        chk("a_restart_lat0", {data_a, vde_a, hs_a, vs_a, fs_a}, 28'h0);
        for (int n = 0; n < 4 * AF + 20; n++) begin
          int f, k;
          logic [27:0] e;
          @(negedge pclk);
          f = n / AF;
          k = n % AF;
          e = (f < 4) ? a_exp(k % AH, k / AH, pat_a[f < 4 ? f : 0], 24'h123456) : 28'h0;
          chk($sformatf("a_px_f%0d_k%0d", f, k), {data_a, vde_a, hs_a, vs_a, fs_a}, e);
          if (f < 4 && k == 0) chk($sformatf("a_cnt_f%0d", f), cnt_a, 16'(f));
          if (f >= 4) chk("a_cnt_idle", cnt_a, 16'd4);
          if (f == 0) begin
            if (vde_a) vde_n++;
            if (hs_a) hs_n++;
            if (vs_a) vs_n++;
          end
          if (n == 50) sel_a = 3'd0;
          if (n == AF + 30) sel_a = 3'd2;
          if (n == 2 * AF + 30) sel_a = 3'd4;
          if (n == 3 * AF + 20) solid_a = 24'hABCDEF;
          if (n == 3 * AF + 42) en_a = 1'b0;
        end
        chk("a_vde_cycles", vde_n, 32);
        chk("a_hs_cycles", hs_n, 14);
        chk("a_vs_cycles", vs_n, 14);
      end
      begin : thread_b
        bit found;
        int n;
        found = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        rst_b = 1'b0;
        en_b = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
          @(negedge pclk);
          if (fs_b) found = 1'b1;
        end
        chk("b_frame_start_seen", found, 1);
        if (found) begin
          n = 0;
          foreach (b_q[i]) begin
            int target;
            target = b_q[i].f * BF + b_q[i].v * BH + b_q[i].h;
            while (n < target) begin
              @(negedge pclk);
              n++;
              if (n % BF == BF / 2 && n / BF + 1 < 3) sel_b = 3'(pat_b[n / BF + 1]);
            end
            chk($sformatf("b_vec%0d", i), {data_b, vde_b}, {b_q[i].d, b_q[i].vde});
          end
        end
      end
      begin : thread_c
        bit found;
        int n;
        found = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        rst_c = 1'b0;
        en_c = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
          @(negedge pclk);
          if (fs_c) found = 1'b1;
        end
        chk("c_frame_start_seen", found, 1);
        if (found) begin
          n = 0;
          foreach (c_q[i]) begin
            int target;
            target = c_q[i].f * CF + c_q[i].v * CH + c_q[i].h;
            while (n < target) begin
              @(negedge pclk);
              n++;
            end
            chk($sformatf("c_box%0d", i), {data_c, vde_c}, {c_q[i].d, c_q[i].vde});
          end
        end
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
